// File: rtl/multilane_deserializer_pkg.sv
// Shared types and constants for the multi-lane frame deserializer.
package deser_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    localparam int DESER_LANES      = 4;
    localparam int DESER_FRAME_BITS = 128;

    // LSB position of a lane's slice inside the flattened frame word.
    function automatic int lane_slice(input int lane, input int frame_bits);
        return lane * frame_bits;
    endfunction

endpackage

// File: rtl/multilane_deserializer_if.sv
// Output frame handshake bundle; frame_parity exists only with DESER_PARITY_EN.
interface deser_out_if #(
    parameter int LANES      = 4,
    parameter int FRAME_BITS = 128
) ();
    logic [LANES*FRAME_BITS-1:0] frame_data;
    logic                        frame_valid;
    logic                        frame_ready;
`ifdef DESER_PARITY_EN
    logic [LANES-1:0]            frame_parity;

    modport master (output frame_data, output frame_valid, output frame_parity, input frame_ready);
    modport slave  (input frame_data, input frame_valid, input frame_parity, output frame_ready);
`else
    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
`endif
endinterface

// File: rtl/multilane_deserializer_lane.sv
// One lane's shift register with direction select, clear/complete and optional
// parity accumulator (DESER_PARITY_EN). candidate is the register value including this bit.
module deser_lane #(
    parameter int FRAME_BITS = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  shift,
    input  logic                  complete,
    input  logic                  msb_first,
    input  logic                  bit_in,
`ifdef DESER_PARITY_EN
    output logic                  parity_cand,
`endif
    output logic [FRAME_BITS-1:0] candidate
);

    logic [FRAME_BITS-1:0] sr_q, sr_d, base;

    always_comb begin
        base = clear ? '0 : sr_q;
        candidate = msb_first ? {base[FRAME_BITS-2:0], bit_in}
                              : {bit_in, base[FRAME_BITS-1:1]};
        sr_d = base;
        if (complete)   sr_d = '0;
        else if (shift) sr_d = candidate;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) sr_q <= '0;
        else          sr_q <= sr_d;
    end

`ifdef DESER_PARITY_EN
    logic par_q, par_d, par_base;

    always_comb begin
        par_base    = clear ? 1'b0 : par_q;
        parity_cand = par_base ^ bit_in;
        par_d       = par_base;
        if (complete)   par_d = 1'b0;
        else if (shift) par_d = parity_cand;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`endif

endmodule

// File: rtl/multilane_deserializer.sv
// Multi-lane deserializer: frame FSM, bit counter, output register, handshake, sticky overflow.
// Optional per-lane frame parity output enabled by DESER_PARITY_EN.
module multilane_deserializer
    import deser_pkg::*;
#(
    parameter int LANES      = DESER_LANES,
    parameter int FRAME_BITS = DESER_FRAME_BITS,
    localparam int CNT_W     = $clog2(FRAME_BITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic [LANES-1:0] lane_in,
    input  logic             frame_sync,
    input  logic             msb_first,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic [CNT_W-1:0] bit_count,
    deser_out_if.master      out_if
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    deser_state_t                state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        order_q, order_d;
    logic [LANES*FRAME_BITS-1:0] data_q, data_d, cand;
    logic                        valid_q, valid_d;
    logic                        ovf_q, ovf_d;
    logic                        clear, shift, complete, bit0, dir, drop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear    = 1'b0;
        shift    = 1'b0;
        complete = 1'b0;
        if (frame_sync) begin
            state_d = SHIFT;
            clear   = 1'b1;
            shift   = shift_en;
            cnt_d   = shift_en ? CNT_W'(1) : '0;
        end else if (state_q == SHIFT && shift_en) begin
            shift = 1'b1;
            if (cnt_q == LAST_BIT) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Bit order is captured on bit 0 and held for the rest of the frame.
        bit0    = shift && (clear || cnt_q == '0);
        dir     = bit0 ? msb_first : order_q;
        order_d = dir;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (complete) begin
            if (!valid_q || out_if.frame_ready) begin
                data_d  = cand;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && out_if.frame_ready) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            order_q <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef DESER_PARITY_EN
    logic [LANES-1:0] par_cand, par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (complete && (!valid_q || out_if.frame_ready)) par_d = par_cand;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) par_q <= '0;
        else          par_q <= par_d;
    end

    assign out_if.frame_parity = par_q;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int LSB = lane_slice(gi, FRAME_BITS);
        deser_lane #(.FRAME_BITS(FRAME_BITS)) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .clear       (clear),
            .shift       (shift),
            .complete    (complete),
            .msb_first   (dir),
            .bit_in      (lane_in[gi]),
`ifdef DESER_PARITY_EN
            .parity_cand (par_cand[gi]),
`endif
            .candidate   (cand[LSB +: FRAME_BITS])
        );
    end

    assign out_if.frame_data  = data_q;
    assign out_if.frame_valid = valid_q;
    assign overflow           = ovf_q;
    assign bit_count          = cnt_q;

endmodule

// File: tb/tb_multilane_deserializer.sv
// Directed bench for multilane_deserializer (LANES=2, FRAME_BITS=8) with a bit-list model.
module tb_multilane_deserializer;

    localparam int L  = 2;
    localparam int FB = 8;

    logic         clk = 1'b0;
    logic         reset_n, shift_en, frame_sync, msb_first, overflow_clr;
    logic [L-1:0] lane_in;
    logic         overflow;
    logic [2:0]   bit_count;

    deser_out_if #(.LANES(L), .FRAME_BITS(FB)) oif ();

    multilane_deserializer #(.LANES(L), .FRAME_BITS(FB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .shift_en     (shift_en),
        .lane_in      (lane_in),
        .frame_sync   (frame_sync),
        .msb_first    (msb_first),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .bit_count    (bit_count),
        .out_if       (oif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remembers the bits of the current frame in arrival order and
    // assembles the frame word only when the last bit arrives.
    logic        mb [L][FB];
    int          m_cnt;
    bit          m_hunt, m_order, m_valid, m_ovf;
    logic [15:0] m_data;
    logic [1:0]  m_par;

    always @(posedge clk) begin
        bit          take, done, drop;
        logic [15:0] cand;
        logic [1:0]  pc;
        take = 0; done = 0; drop = 0; cand = '0; pc = '0;
        if (!reset_n) begin
            m_hunt = 1; m_cnt = 0; m_order = 1; m_data = '0;
            m_valid = 0; m_ovf = 0; m_par = '0;
        end else begin
            if (frame_sync) begin
                m_hunt = 0; m_cnt = 0; take = shift_en;
            end else if (!m_hunt && shift_en) begin
                take = 1;
            end
            if (take) begin
                if (m_cnt == 0) m_order = msb_first;
                for (int l = 0; l < L; l++) mb[l][m_cnt] = lane_in[l];
                m_cnt++;
                if (m_cnt == FB) begin done = 1; m_cnt = 0; end
            end
            if (done) begin
                for (int l = 0; l < L; l++)
                    for (int k = 0; k < FB; k++) begin
                        if (m_order) cand[l*FB + (FB-1-k)] = mb[l][k];
                        else         cand[l*FB + k]        = mb[l][k];
                        pc[l] = pc[l] ^ mb[l][k];
                    end
                if (!m_valid || oif.frame_ready) begin
                    m_data = cand; m_valid = 1; m_par = pc;
                end else begin
                    drop = 1;
                end
            end else if (m_valid && oif.frame_ready) begin
                m_valid = 0;
            end
            if (drop)              m_ovf = 1;
            else if (overflow_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_valid", 64'(oif.frame_valid), 64'(m_valid));
            check("cyc_data", 64'(oif.frame_data), 64'(m_data));
            check("cyc_overflow", 64'(overflow), 64'(m_ovf));
            check("cyc_bit_count", 64'(bit_count), 64'(m_cnt));
`ifdef DESER_PARITY_EN
            check("cyc_parity", 64'(oif.frame_parity), 64'(m_par));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame; byte bit 7 goes first, so MSB-first yields the byte itself.
    // msb_first is inverted after bit 0 to show the order is latched.
    task automatic send_frame(input logic [7:0] l0, input logic [7:0] l1,
                              input bit msb, input bit sync, input bit ready_last);
        for (int k = 0; k < FB; k++) begin
            shift_en   = 1'b1;
            frame_sync = sync && (k == 0);
            msb_first  = (k == 0) ? msb : ~msb;
            lane_in    = {l1[7-k], l0[7-k]};
            if (ready_last && k == FB-1) oif.frame_ready = 1'b1;
            tick();
            if (k == 0) check("bit_count_first", 64'(bit_count), 64'd1);
        end
        shift_en = 1'b0; frame_sync = 1'b0; lane_in = '0;
    endtask

    initial begin
        reset_n = 0; shift_en = 0; frame_sync = 0; msb_first = 1;
        overflow_clr = 0; lane_in = '0; oif.frame_ready = 0;
        tick();
        started = 1;
        tick();
        reset_n = 1;
        check("reset_valid", 64'(oif.frame_valid), 64'd0);
        check("reset_data", 64'(oif.frame_data), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        $display("txn reset done");

        // MSB-first frame, consumer ready
        oif.frame_ready = 1;
        send_frame(8'hB2, 8'hFF, 1'b1, 1'b1, 1'b0);
        check("msb_valid", 64'(oif.frame_valid), 64'd1);
        check("msb_data", 64'(oif.frame_data), 64'hFFB2);
        tick();
        check("msb_valid_drop", 64'(oif.frame_valid), 64'd0);
        check("msb_data_hold", 64'(oif.frame_data), 64'hFFB2);
        $display("txn msb-first frame data=%h", oif.frame_data);

        // Same stream, LSB-first
        send_frame(8'hB2, 8'hFF, 1'b0, 1'b1, 1'b0);
        check("lsb_data", 64'(oif.frame_data), 64'hFF4D);
        tick();
        $display("txn lsb-first frame data=%h", oif.frame_data);

        // Back-to-back frames with consumer stalled
        oif.frame_ready = 0;
        send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("b2b_first_data", 64'(oif.frame_data), 64'h3CA5);
        check("b2b_first_ovf", 64'(overflow), 64'd0);
        send_frame(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        check("b2b_ovf_set", 64'(overflow), 64'd1);
        check("b2b_data_held", 64'(oif.frame_data), 64'h3CA5);
        overflow_clr = 1;
        tick();
        overflow_clr = 0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        check("ovf_clr_data", 64'(oif.frame_data), 64'h3CA5);
        $display("txn back-to-back overflow data=%h", oif.frame_data);

        // Completion coinciding with consume
        send_frame(8'h96, 8'h55, 1'b1, 1'b0, 1'b1);
        check("coincide_valid", 64'(oif.frame_valid), 64'd1);
        check("coincide_data", 64'(oif.frame_data), 64'h5596);
        check("coincide_ovf", 64'(overflow), 64'd0);
        tick();
        check("coincide_drop", 64'(oif.frame_valid), 64'd0);
        $display("txn completion+consume data=%h", oif.frame_data);

        // Resync after 5 bits
        for (int k = 0; k < 5; k++) begin
            shift_en = 1; frame_sync = (k == 0); lane_in = 2'b11;
            tick();
        end
        shift_en = 0; frame_sync = 0;
        check("partial_count", 64'(bit_count), 64'd5);
        send_frame(8'h81, 8'h7E, 1'b1, 1'b1, 1'b0);
        check("resync_data", 64'(oif.frame_data), 64'h7E81);
        tick();
        $display("txn resync data=%h", oif.frame_data);

        // Reset mid-frame with a pending frame
        oif.frame_ready = 0;
        send_frame(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            shift_en = 1; lane_in = 2'b10;
            tick();
        end
        shift_en = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        check("midreset_valid", 64'(oif.frame_valid), 64'd0);
        check("midreset_data", 64'(oif.frame_data), 64'd0);
        check("midreset_count", 64'(bit_count), 64'd0);
        for (int k = 0; k < 4; k++) begin
            shift_en = 1; lane_in = 2'b11;
            tick();
        end
        shift_en = 0;
        check("hunt_ignore_count", 64'(bit_count), 64'd0);
        check("hunt_ignore_valid", 64'(oif.frame_valid), 64'd0);
        frame_sync = 1;
        tick();
        frame_sync = 0;
        check("sync_noshift_count", 64'(bit_count), 64'd0);
        send_frame(8'hC1, 8'h1E, 1'b0, 1'b0, 1'b0);
        check("post_reset_data", 64'(oif.frame_data), 64'h7883);
        tick();
        $display("txn reset recovery data=%h", oif.frame_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
